// File: rtl/elevator_fsm.sv
// Four-floor elevator controller: latches calls, travels with direction persistence,
// times floor-to-floor motion and door dwell, and drives the piso/accion/puertas bus.
module elevator_fsm #(
  parameter int unsigned TRAVEL_CYCLES = 8,
  parameter int unsigned DOOR_CYCLES   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] boton,
  output logic [1:0] piso,
  output logic [1:0] accion,
  output logic       puertas
);

  typedef enum logic [1:0] {IDLE, SUBE, BAJA, PUERTA} state_t;

  localparam logic [15:0] TRAVEL_LAST = 16'(TRAVEL_CYCLES - 1);
  localparam logic [15:0] DOOR_LAST   = 16'(DOOR_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  piso_q, piso_d;
  logic [1:0]  accion_q, accion_d;
  logic        puertas_q, puertas_d;
  logic [3:0]  pend_q, pend_d;
  logic [15:0] cnt_q, cnt_d;
  logic        dir_up_q, dir_up_d;
  logic [3:0]  req;
  logic [1:0]  new_floor;
  logic        any_above, any_below;

  function automatic logic [3:0] above_mask(input logic [1:0] f);
    above_mask = 4'b1110 << f;
  endfunction

  function automatic logic [3:0] below_mask(input logic [1:0] f);
    below_mask = (4'b0001 << f) - 4'b0001;
  endfunction

  always_comb begin
    state_d   = state_q;
    piso_d    = piso_q;
    cnt_d     = cnt_q;
    dir_up_d  = dir_up_q;
    req       = pend_q | boton;
    pend_d    = req;
    new_floor = piso_q;
    any_above = |(pend_q & above_mask(piso_q));
    any_below = |(pend_q & below_mask(piso_q));

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pend_q[piso_q]) begin
          state_d        = PUERTA;
          pend_d[piso_q] = 1'b0;
        end else if (any_above && (dir_up_q || !any_below)) begin
          state_d  = SUBE;
          dir_up_d = 1'b1;
        end else if (any_below) begin
          state_d  = BAJA;
          dir_up_d = 1'b0;
        end
      end

      SUBE, BAJA: begin
        if (cnt_q == TRAVEL_LAST) begin
          new_floor = (state_q == SUBE) ? piso_q + 2'd1 : piso_q - 2'd1;
          piso_d    = new_floor;
          cnt_d     = '0;
          // Arrival decision sees calls made on this very edge.
          if (req[new_floor]) begin
            state_d           = PUERTA;
            pend_d[new_floor] = 1'b0;
          end else if (state_q == SUBE ? |(req & above_mask(new_floor))
                                       : |(req & below_mask(new_floor))) begin
            state_d = state_q;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      PUERTA: begin
        // A call for the open floor only extends the dwell.
        pend_d[piso_q] = pend_q[piso_q];
        if (boton[piso_q]) begin
          cnt_d = '0;
        end else if (cnt_q == DOOR_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: state_d = IDLE;
    endcase

    case (state_d)
      SUBE:    accion_d = 2'd1;
      BAJA:    accion_d = 2'd2;
      default: accion_d = 2'd0;
    endcase
    puertas_d = (state_d == PUERTA);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      piso_q    <= 2'd0;
      accion_q  <= 2'd0;
      puertas_q <= 1'b0;
      pend_q    <= 4'd0;
      cnt_q     <= 16'd0;
      dir_up_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      piso_q    <= piso_d;
      accion_q  <= accion_d;
      puertas_q <= puertas_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      dir_up_q  <= dir_up_d;
    end
  end

  assign piso    = piso_q;
  assign accion  = accion_q;
  assign puertas = puertas_q;

endmodule

// File: tb/tb_elevator_fsm.sv
// Self-checking bench for elevator_fsm: directed scenarios and random calls
// compared cycle by cycle against a countdown-timer model of the car.
module tb_elevator_fsm;

  localparam int TRAVEL_CYCLES = 8;
  localparam int DOOR_CYCLES   = 5;

  logic       clk;
  logic       rst;
  logic [3:0] boton;
  logic [1:0] piso;
  logic [1:0] accion;
  logic       puertas;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: floor, motion (0 stop, 1 up, 2 down), door, remaining cycles.
  int       m_floor, m_motion, m_left;
  bit       m_door, m_last_up;
  bit [3:0] m_pend;

  elevator_fsm #(.TRAVEL_CYCLES(TRAVEL_CYCLES), .DOOR_CYCLES(DOOR_CYCLES)) dut (
    .clk(clk), .rst(rst), .boton(boton),
    .piso(piso), .accion(accion), .puertas(puertas)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_floor = 0; m_motion = 0; m_left = 0; m_door = 0; m_last_up = 1; m_pend = '0;
  endtask

  task automatic model_step(input logic [3:0] b);
    bit [3:0] seen;
    bit up_req, down_req;
    seen = m_pend;
    for (int i = 0; i < 4; i++)
      if (b[i] && !(m_door && i == m_floor)) m_pend[i] = 1'b1;
    if (m_door) begin
      if (b[m_floor]) m_left = DOOR_CYCLES;
      else begin
        m_left--;
        if (m_left == 0) m_door = 0;
      end
    end else if (m_motion != 0) begin
      m_left--;
      if (m_left == 0) begin
        m_floor = m_floor + ((m_motion == 1) ? 1 : -1);
        up_req = 0; down_req = 0;
        for (int i = 0; i < 4; i++) begin
          if (m_pend[i] && i > m_floor) up_req = 1;
          if (m_pend[i] && i < m_floor) down_req = 1;
        end
        if (m_pend[m_floor]) begin
          m_pend[m_floor] = 0; m_motion = 0; m_door = 1; m_left = DOOR_CYCLES;
        end else if ((m_motion == 1 && up_req) || (m_motion == 2 && down_req)) begin
          m_left = TRAVEL_CYCLES;
        end else begin
          m_motion = 0;
        end
      end
    end else begin
      up_req = 0; down_req = 0;
      for (int i = 0; i < 4; i++) begin
        if (seen[i] && i > m_floor) up_req = 1;
        if (seen[i] && i < m_floor) down_req = 1;
      end
      if (seen[m_floor]) begin
        m_pend[m_floor] = 0; m_door = 1; m_left = DOOR_CYCLES;
      end else if (up_req && (m_last_up || !down_req)) begin
        m_motion = 1; m_last_up = 1; m_left = TRAVEL_CYCLES;
      end else if (down_req) begin
        m_motion = 2; m_last_up = 0; m_left = TRAVEL_CYCLES;
      end
    end
  endtask

  // Drive one edge's worth of calls; returns at the following falling edge.
  task automatic tick(input logic [3:0] b);
    boton = b;
    @(posedge clk);
    model_step(b);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    boton = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    boton = 4'b1111;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (piso !== 2'd0 || accion !== 2'd0 || puertas !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold k=%0d got %0d/%0d/%0d want 0/0/0", k, piso, accion, puertas);
      end
    end
    rst = 1'b1;
    tick(4'b1111);
    tick(4'b0000);
    n_cmp++;
    if (puertas !== 1'b1 || piso !== 2'd0 || accion !== 2'd0) begin
      n_err++;
      $display("FAIL reset_first_stop got piso=%0d accion=%0d puertas=%0d want 0/0/1", piso, accion, puertas);
    end
    for (int k = 0; k < 100; k++) begin
      tick(4'b0000);
      n_cmp++;
      if (piso !== 2'(m_floor) || accion !== 2'(m_motion) || puertas !== m_door) begin
        n_err++;
        $display("FAIL reset_drain k=%0d got %0d/%0d/%0d want %0d/%0d/%0d",
                 k, piso, accion, puertas, m_floor, m_motion, m_door);
      end
    end
    $display("test_reset: done");
  endtask

  task automatic test_local_call();
    int open_cnt, first_open;
    do_reset();
    open_cnt = 0; first_open = -1;
    for (int k = 1; k <= 20; k++) begin
      tick(k == 1 ? 4'b0001 : 4'b0000);
      n_cmp++;
      if (piso !== 2'(m_floor) || accion !== 2'(m_motion) || puertas !== m_door || accion !== 2'd0) begin
        n_err++;
        $display("FAIL local_call k=%0d got %0d/%0d/%0d want %0d/%0d/%0d",
                 k, piso, accion, puertas, m_floor, m_motion, m_door);
      end
      if (puertas === 1'b1) begin
        open_cnt++;
        if (first_open < 0) first_open = k;
      end
    end
    n_cmp++;
    if (open_cnt != DOOR_CYCLES || first_open != 2) begin
      n_err++;
      $display("FAIL local_call_dwell got open=%0d first=%0d want open=%0d first=2",
               open_cnt, first_open, DOOR_CYCLES);
    end
    $display("test_local_call: done");
  endtask

  task automatic test_two_floor();
    int up_cnt, first_move, t1, t2;
    logic door_at_t2, acc_at_t2;
    do_reset();
    up_cnt = 0; first_move = -1; t1 = -1; t2 = -1; door_at_t2 = 0; acc_at_t2 = 1;
    for (int k = 1; k <= 40; k++) begin
      tick(k == 1 ? 4'b0100 : 4'b0000);
      n_cmp++;
      if (piso !== 2'(m_floor) || accion !== 2'(m_motion) || puertas !== m_door) begin
        n_err++;
        $display("FAIL two_floor k=%0d got %0d/%0d/%0d want %0d/%0d/%0d",
                 k, piso, accion, puertas, m_floor, m_motion, m_door);
      end
      if (accion === 2'd1) begin
        up_cnt++;
        if (first_move < 0) first_move = k;
      end
      if (piso === 2'd1 && t1 < 0) t1 = k;
      if (piso === 2'd2 && t2 < 0) begin
        t2 = k; door_at_t2 = puertas; acc_at_t2 = (accion != 2'd0);
      end
    end
    n_cmp++;
    if (first_move != 2 || up_cnt != 2 * TRAVEL_CYCLES || t1 != first_move + TRAVEL_CYCLES
        || t2 != first_move + 2 * TRAVEL_CYCLES || door_at_t2 !== 1'b1 || acc_at_t2 !== 1'b0) begin
      n_err++;
      $display("FAIL two_floor_timing got move=%0d up=%0d t1=%0d t2=%0d door=%0d moving=%0d want 2/16/10/18/1/0",
               first_move, up_cnt, t1, t2, door_at_t2, acc_at_t2);
    end
    $display("test_two_floor: done");
  endtask

  task automatic test_intermediate();
    int stops[$];
    int close_k, restart_k;
    logic prev_door;
    do_reset();
    close_k = -1; restart_k = -1; prev_door = 0;
    for (int k = 1; k <= 70; k++) begin
      tick(k == 1 ? 4'b1010 : 4'b0000);
      n_cmp++;
      if (piso !== 2'(m_floor) || accion !== 2'(m_motion) || puertas !== m_door) begin
        n_err++;
        $display("FAIL intermediate k=%0d got %0d/%0d/%0d want %0d/%0d/%0d",
                 k, piso, accion, puertas, m_floor, m_motion, m_door);
      end
      if (puertas === 1'b1 && !prev_door) stops.push_back(int'(piso));
      if (puertas === 1'b0 && prev_door && close_k < 0) close_k = k;
      if (close_k > 0 && restart_k < 0 && accion === 2'd1) restart_k = k;
      prev_door = puertas;
    end
    n_cmp++;
    if (stops.size() != 2 || stops[0] != 1 || stops[1] != 3 || restart_k - close_k != 1
        || piso !== 2'd3 || accion !== 2'd0 || puertas !== 1'b0) begin
      n_err++;
      $display("FAIL intermediate_stops got nstops=%0d idle_gap=%0d piso=%0d want stops 1,3 gap 1 piso 3",
               stops.size(), restart_k - close_k, piso);
    end
    $display("test_intermediate: done");
  endtask

  task automatic test_direction();
    int stops[$];
    logic prev_door, saw_down;
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      tick(k == 1 ? 4'b0100 : 4'b0000);
      n_cmp++;
      if (piso !== 2'(m_floor) || accion !== 2'(m_motion) || puertas !== m_door) begin
        n_err++;
        $display("FAIL direction_setup k=%0d got %0d/%0d/%0d want %0d/%0d/%0d",
                 k, piso, accion, puertas, m_floor, m_motion, m_door);
      end
    end
    prev_door = 0; saw_down = 0;
    for (int k = 1; k <= 80; k++) begin
      tick(k == 1 ? 4'b1001 : 4'b0000);
      n_cmp++;
      if (piso !== 2'(m_floor) || accion !== 2'(m_motion) || puertas !== m_door) begin
        n_err++;
        $display("FAIL direction k=%0d got %0d/%0d/%0d want %0d/%0d/%0d",
                 k, piso, accion, puertas, m_floor, m_motion, m_door);
      end
      if (puertas === 1'b1 && !prev_door) stops.push_back(int'(piso));
      if (accion === 2'd2) saw_down = 1;
      prev_door = puertas;
    end
    n_cmp++;
    if (stops.size() != 2 || stops[0] != 3 || stops[1] != 0 || !saw_down) begin
      n_err++;
      $display("FAIL direction_order got nstops=%0d first=%0d down=%0d want stops 3,0 with downward travel",
               stops.size(), (stops.size() > 0) ? stops[0] : -1, saw_down);
    end
    $display("test_direction: done");
  endtask

  task automatic test_door_extend();
    int open_cnt;
    do_reset();
    open_cnt = 0;
    for (int k = 1; k <= 25; k++) begin
      tick((k == 1 || k == 5) ? 4'b0001 : 4'b0000);
      n_cmp++;
      if (piso !== 2'(m_floor) || accion !== 2'(m_motion) || puertas !== m_door) begin
        n_err++;
        $display("FAIL door_extend k=%0d got %0d/%0d/%0d want %0d/%0d/%0d",
                 k, piso, accion, puertas, m_floor, m_motion, m_door);
      end
      if (puertas === 1'b1) open_cnt++;
    end
    n_cmp++;
    if (open_cnt != 3 + DOOR_CYCLES) begin
      n_err++;
      $display("FAIL door_extend_dwell got open=%0d want %0d", open_cnt, 3 + DOOR_CYCLES);
    end
    $display("test_door_extend: done");
  endtask

  task automatic test_reset_mid_travel();
    do_reset();
    for (int k = 1; k <= 14; k++) tick(k == 1 ? 4'b0100 : 4'b0000);
    n_cmp++;
    if (piso !== 2'd1 || accion !== 2'd1) begin
      n_err++;
      $display("FAIL mid_travel_pos got piso=%0d accion=%0d want 1/1", piso, accion);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (piso !== 2'd0 || accion !== 2'd0 || puertas !== 1'b0) begin
      n_err++;
      $display("FAIL mid_travel_async got %0d/%0d/%0d want 0/0/0", piso, accion, puertas);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick(4'b0000);
      n_cmp++;
      if (piso !== 2'd0 || accion !== 2'd0 || puertas !== 1'b0 || accion !== 2'(m_motion)) begin
        n_err++;
        $display("FAIL mid_travel_after k=%0d got %0d/%0d/%0d want 0/0/0", k, piso, accion, puertas);
      end
    end
    $display("test_reset_mid_travel: done");
  endtask

  task automatic test_random();
    logic [3:0] b;
    do_reset();
    for (int k = 1; k <= 2000; k++) begin
      b = ($urandom_range(0, 6) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      tick(b);
      n_cmp++;
      if (piso !== 2'(m_floor) || accion !== 2'(m_motion) || puertas !== m_door) begin
        n_err++;
        $display("FAIL random k=%0d boton=%b got %0d/%0d/%0d want %0d/%0d/%0d",
                 k, b, piso, accion, puertas, m_floor, m_motion, m_door);
      end
    end
    $display("test_random: done");
  endtask

  initial begin
    rst = 1'b0;
    boton = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_local_call();
    test_two_floor();
    test_intermediate();
    test_direction();
    test_door_extend();
    test_reset_mid_travel();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
